adc_sequencer: RTL and testbench

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_sequencer_if.sv | 34 +++
 rtl/adc_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_adc_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sequencer_if.sv
`default_nettype none
// ============================================================================
// adc_if -- bus between the scan sequencer and the ADC macro (enable/mux/convert/result)
// Revision 1.0
// ============================================================================
interface adc_if #(
  parameter int NCH = 4,
  parameter int DW  = 10
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          adc_ena;
  logic [SW-1:0] adc_sel;
  logic          adc_convert;
  logic          adc_done;
  logic [DW-1:0] adc_data;

  modport master (
    output adc_ena,
    output adc_sel,
    output adc_convert,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_ena,
    input  adc_sel,
    input  adc_convert,
    output adc_done,
    output adc_data
  );
endinterface
`default_nettype wire

// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
// adc_sequencer -- masked multi-channel ADC scan engine; ADC_SEQ_AVERAGE_EN enables 4x averaging
// Revision 1.0
// ============================================================================
module adc_sequencer #(
  parameter int NCH     = 4,
  parameter int DW      = 10,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     cfg_en,
  input  logic [NCH-1:0]                           cfg_mask,
  input  logic [15:0]                              cfg_period,
  input  logic                                     trig,
  adc_if.master                                    adc,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_sel,
  input  logic                                     rd_stb,
  output logic [DW-1:0]                            rd_data,
  output logic [NCH-1:0]                           res_valid,
  output logic                                     busy,
  output logic                                     scan_done,
  output logic                                     err_timeout
);

  localparam int SW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SETTLE_N  = (SETTLE < 1) ? 1 : SETTLE;
  localparam int TIMEOUT_N = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int SCW       = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam int TCW       = (TIMEOUT_N > 1) ? $clog2(TIMEOUT_N) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_N - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CONVERT = 3'd3,
    S_WAIT    = 3'd4,
    S_STORE   = 3'd5
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [NCH-1:0] pending;
  logic [SW-1:0]  sel_r;
  logic [SW-1:0]  pick_idx;
  logic [SCW-1:0] settle_cnt;
  logic [TCW-1:0] wait_cnt;
  logic [15:0]    per_cnt;
  logic           done_q;
  logic           ena_r;
  logic           scan_done_r;
  logic           err_r;
  logic [DW-1:0]  result [NCH];

  logic           per_en;
  logic           per_expire;
  logic           start;
  logic           done_rise;
  logic           chan_last;
  logic           scan_last;
  logic           store_en;
  logic           timeout_hit;
  logic [NCH-1:0] sel_onehot;
  logic [NCH-1:0] remaining;
  logic [DW-1:0]  store_val;

`ifdef ADC_SEQ_AVERAGE_EN
  logic [1:0]     rep;
  logic [DW+1:0]  acc;

  assign chan_last = (rep == 2'd3);
  assign store_val = acc[DW+1:2];
`else
  logic [DW-1:0]  sample;

  assign chan_last = 1'b1;
  assign store_val = sample;
`endif

  // A period expiry seen while busy reloads the counter and is simply dropped.
  assign per_en      = cfg_en && (cfg_period != 16'd0);
  assign per_expire  = per_en && (per_cnt <= 16'd1);
  assign start       = (state == S_IDLE) && cfg_en && (cfg_mask != '0) && (trig || per_expire);
  assign done_rise   = adc.adc_done && !done_q;
  assign sel_onehot  = NCH'(1) << sel_r;
  assign remaining   = pending & ~sel_onehot;
  assign scan_last   = chan_last && (remaining == '0);
  assign store_en    = (state == S_STORE) && cfg_en && chan_last;
  assign timeout_hit = (state == S_WAIT) && cfg_en && !done_rise && (wait_cnt == TIMEOUT_LAST);

  assign adc.adc_ena     = ena_r;
  assign adc.adc_sel     = sel_r;
  assign adc.adc_convert = (state == S_CONVERT);
  assign busy            = (state != S_IDLE);
  assign scan_done       = scan_done_r;
  assign err_timeout     = err_r;

  always_comb begin
    pick_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_idx = SW'(i);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SW'(i)) begin
        rd_data = result[i];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_SELECT;
      S_SELECT:  next_state = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = S_CONVERT;
      S_CONVERT: next_state = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          next_state = S_STORE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          next_state = S_IDLE;
        end
      end
      S_STORE:   next_state = scan_last ? S_IDLE : S_SELECT;
      default:   next_state = S_IDLE;
    endcase
    if ((state != S_IDLE) && !cfg_en) begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      sel_r       <= '0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      per_cnt     <= '0;
      done_q      <= 1'b0;
      ena_r       <= 1'b0;
      scan_done_r <= 1'b0;
      err_r       <= 1'b0;
      res_valid   <= '0;
      for (int i = 0; i < NCH; i++) begin
        result[i] <= '0;
      end
`ifdef ADC_SEQ_AVERAGE_EN
      rep         <= 2'd0;
      acc         <= '0;
`else
      sample      <= '0;
`endif
    end else begin
      done_q      <= adc.adc_done;
      ena_r       <= cfg_en;
      scan_done_r <= (state == S_STORE) && cfg_en && scan_last;

      if (!per_en) begin
        per_cnt <= 16'd0;
      end else if (start || (per_cnt <= 16'd1)) begin
        per_cnt <= cfg_period;
      end else begin
        per_cnt <= per_cnt - 16'd1;
      end

      if (timeout_hit) begin
        err_r <= 1'b1;
      end else if (trig) begin
        err_r <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            pending <= cfg_mask;
`ifdef ADC_SEQ_AVERAGE_EN
            rep     <= 2'd0;
`endif
          end
        end
        S_SELECT: begin
          sel_r      <= pick_idx;
          settle_cnt <= '0;
`ifdef ADC_SEQ_AVERAGE_EN
          if (rep == 2'd0) begin
            acc <= '0;
          end
`endif
        end
        S_SETTLE:  settle_cnt <= settle_cnt + 1'b1;
        S_CONVERT: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (done_rise) begin
`ifdef ADC_SEQ_AVERAGE_EN
            acc <= acc + (DW+2)'(adc.adc_data);
`else
            sample <= adc.adc_data;
`endif
          end
        end
        S_STORE: begin
          // The channel stays pending until its last sample, so SELECT re-picks it.
          if (chan_last) begin
            pending <= remaining;
          end
`ifdef ADC_SEQ_AVERAGE_EN
          rep <= rep + 2'd1;
`endif
        end
        default: ;
      endcase

      // A store beats a same-cycle read strobe on the same channel.
      for (int i = 0; i < NCH; i++) begin
        if (store_en && (sel_r == SW'(i))) begin
          result[i]    <= store_val;
          res_valid[i] <= 1'b1;
        end else if (rd_stb && (rd_sel == SW'(i))) begin
          res_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_sequencer.sv
`default_nettype none
// tb_adc_sequencer -- directed/randomized scans checked against a scan-level reference model.
module tb_adc_sequencer;

  localparam int NCH     = 4;
  localparam int DW      = 10;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;
`ifdef ADC_SEQ_AVERAGE_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_en;
  logic [NCH-1:0] cfg_mask;
  logic [15:0]    cfg_period;
  logic           trig;
  logic [1:0]     rd_sel;
  logic           rd_stb;
  logic [DW-1:0]  rd_data;
  logic [NCH-1:0] res_valid;
  logic           busy;
  logic           scan_done;
  logic           err_timeout;

  adc_if #(.NCH(NCH), .DW(DW)) adc ();

  adc_sequencer #(.NCH(NCH), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_en      (cfg_en),
    .cfg_mask    (cfg_mask),
    .cfg_period  (cfg_period),
    .trig        (trig),
    .adc         (adc),
    .rd_sel      (rd_sel),
    .rd_stb      (rd_stb),
    .rd_data     (rd_data),
    .res_valid   (res_valid),
    .busy        (busy),
    .scan_done   (scan_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int adc_lat = 5;
  bit adc_mute = 1'b0;
  int fdata[$];
  int sel_log[$];
  int data_log[$];

  int cyc = 0;
  int rise_cyc[$];
  int sd_cnt = 0;
  int conv_cnt = 0;
  logic busy_prev = 1'b0;

  logic [DW-1:0]  exp_res [NCH];
  logic [NCH-1:0] exp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADC macro model: done rises adc_lat cycles after a convert pulse, held two cycles.
  initial begin
    adc.adc_done = 1'b0;
    adc.adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc.adc_convert === 1'b1) begin
        int d;
        d = (fdata.size() > 0) ? fdata.pop_front() : int'($urandom_range(0, (1 << DW) - 1));
        sel_log.push_back(int'(adc.adc_sel));
        if (!adc_mute) begin
          data_log.push_back(d);
          repeat (adc_lat) @(negedge clk);
          adc.adc_done = 1'b1;
          adc.adc_data = DW'(d);
          repeat (2) @(negedge clk);
          adc.adc_done = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_prev) rise_cyc.push_back(cyc);
      busy_prev = busy;
      if (scan_done) sd_cnt++;
      if (adc.adc_convert) conv_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic verify_results(input string tag);
    for (int c = 0; c < NCH; c++) begin
      rd_sel = 2'(c);
      #1;
      check($sformatf("%s_res%0d", tag, c), rd_data, exp_res[c]);
    end
    check({tag, "_valid"}, res_valid, exp_valid);
  endtask

  // Scan-level model: lowest-first channel order, fixed per-conversion latency, mean of REPS samples.
  task automatic do_scan(input logic [NCH-1:0] mask, input int lat, input string tag);
    int ord[$];
    int cnt;
    int sum;
    for (int c = 0; c < NCH; c++) if (mask[c]) ord.push_back(c);
    sel_log.delete();
    data_log.delete();
    sd_cnt = 0;
    conv_cnt = 0;
    adc_lat = lat;
    cfg_mask = mask;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    check({tag, "_err_clr"}, err_timeout, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      tick(1);
      cnt++;
    end
    check({tag, "_busy_len"}, cnt, ord.size() * REPS * (SETTLE + 3 + lat));
    check({tag, "_scan_done"}, scan_done, 1);
    tick(2);
    check({tag, "_done_cnt"}, sd_cnt, 1);
    check({tag, "_conv_cnt"}, conv_cnt, ord.size() * REPS);
    for (int k = 0; k < sel_log.size() && k < ord.size() * REPS; k++)
      check($sformatf("%s_sel%0d", tag, k), sel_log[k], ord[k / REPS]);
    for (int i = 0; i < ord.size(); i++) begin
      sum = 0;
      for (int r = 0; r < REPS; r++)
        if (data_log.size() > i * REPS + r) sum += data_log[i * REPS + r];
      exp_res[ord[i]] = DW'(sum / REPS);
      exp_valid[ord[i]] = 1'b1;
    end
    verify_results(tag);
  endtask

  initial begin
    int cnt;
    int seen;
    int sum;
    logic prev;
    logic [NCH-1:0] m;
    int ch;

    reset = 1'b1;
    cfg_en = 1'b0;
    cfg_mask = '0;
    cfg_period = 16'd0;
    trig = 1'b0;
    rd_sel = 2'd0;
    rd_stb = 1'b0;
    exp_valid = '0;
    for (int c = 0; c < NCH; c++) exp_res[c] = '0;
    tick(3);

    check("rst_ena", adc.adc_ena, 0);
    check("rst_sel", adc.adc_sel, 0);
    check("rst_convert", adc.adc_convert, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_err", err_timeout, 0);
    verify_results("rst");

    reset = 1'b0;
    cfg_mask = 4'b1111;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    check("dis_trig_busy", busy, 0);
    check("dis_ena", adc.adc_ena, 0);
    cfg_en = 1'b1;
    cfg_mask = 4'b0000;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    check("nomask_busy", busy, 0);
    check("en_ena", adc.adc_ena, 1);

    for (int r = 0; r < REPS; r++) fdata.push_back('h155);
    for (int r = 0; r < REPS; r++) fdata.push_back('h2AA);
    do_scan(4'b0101, 20, "basic");
    check("basic_r0", exp_res[0], 'h155);
    check("basic_r2", exp_res[2], 'h2AA);

    for (int it = 0; it < 4; it++) begin
      m = NCH'($urandom_range(1, 15));
      do_scan(m, int'($urandom_range(1, 12)), $sformatf("rnd%0d", it));
      ch = int'($urandom_range(0, NCH - 1));
      rd_sel = 2'(ch);
      rd_stb = 1'b1;
      tick(1);
      rd_stb = 1'b0;
      exp_valid[ch] = 1'b0;
      check($sformatf("rnd%0d_rdclr", it), res_valid, exp_valid);
    end

    // Timeout: ADC never answers.
    adc_mute = 1'b1;
    sd_cnt = 0;
    cfg_mask = 4'b0001;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      tick(1);
      cnt++;
    end
    check("to_len", cnt, 1 + SETTLE + 1 + TIMEOUT);
    check("to_err", err_timeout, 1);
    check("to_busy", busy, 0);
    tick(2);
    check("to_no_done", sd_cnt, 0);
    verify_results("to");
    adc_mute = 1'b0;
    do_scan(4'b0001, 3, "after_to");

    // Read strobe colliding with the final store of channel 1.
    sel_log.delete();
    data_log.delete();
    adc_lat = 6;
    cfg_mask = 4'b0010;
    prev = adc.adc_done;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    seen = 0;
    cnt = 0;
    while (seen < REPS && cnt < 2000) begin
      if (adc.adc_done && !prev) seen++;
      prev = adc.adc_done;
      if (seen < REPS) begin
        tick(1);
        cnt++;
      end
    end
    check("coll_wait", seen, REPS);
    rd_sel = 2'd1;
    rd_stb = 1'b1;
    tick(1);
    check("coll_store_wins", res_valid[1], 1);
    tick(1);
    rd_stb = 1'b0;
    check("coll_later_clear", res_valid[1], 0);
    tick(3);
    sum = 0;
    for (int r = 0; r < REPS && r < data_log.size(); r++) sum += data_log[r];
    exp_res[1] = DW'(sum / REPS);
    exp_valid[1] = 1'b0;
    verify_results("coll");

    // Periodic trigger every 1000 cycles; a trig while busy must not add a scan.
    data_log.delete();
    adc_lat = 5;
    cfg_mask = 4'b0001;
    rise_cyc.delete();
    sd_cnt = 0;
    cfg_period = 16'd1000;
    cnt = 0;
    while (rise_cyc.size() == 0 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("per_first", rise_cyc.size(), 1);
    check("per_busy", busy, 1);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(2050);
    check("per_scans", rise_cyc.size(), 3);
    check("per_dones", sd_cnt, 3);
    if (rise_cyc.size() >= 3) begin
      check("per_int1", rise_cyc[1] - rise_cyc[0], 1000);
      check("per_int2", rise_cyc[2] - rise_cyc[1], 1000);
    end
    cfg_period = 16'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    tick(2);
    if (data_log.size() >= REPS) begin
      sum = 0;
      for (int r = 0; r < REPS; r++) sum += data_log[data_log.size() - REPS + r];
      exp_res[0] = DW'(sum / REPS);
      exp_valid[0] = 1'b1;
    end
    verify_results("per");

    // Enable dropped during WAIT.
    cfg_mask = 4'b0011;
    adc_lat = 20;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(12);
    check("abort_in_wait", busy, 1);
    cfg_en = 1'b0;
    sd_cnt = 0;
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_ena", adc.adc_ena, 0);
    tick(30);
    check("abort_no_done", sd_cnt, 0);
    verify_results("abort");

    // Reset in the middle of a conversion; the later done must be ignored.
    cfg_en = 1'b1;
    tick(1);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sd_cnt = 0;
    for (int c = 0; c < NCH; c++) exp_res[c] = '0;
    exp_valid = '0;
    check("mrst_ena", adc.adc_ena, 0);
    check("mrst_sel", adc.adc_sel, 0);
    check("mrst_convert", adc.adc_convert, 0);
    check("mrst_busy", busy, 0);
    check("mrst_scan_done", scan_done, 0);
    check("mrst_err", err_timeout, 0);
    verify_results("mrst");
    tick(40);
    check("mrst_late_busy", busy, 0);
    check("mrst_late_done", sd_cnt, 0);
    check("mrst_late_ena", adc.adc_ena, 1);
    verify_results("mrst_late");

    do_scan(4'b1110, 2, "recover");

`ifdef ADC_SEQ_AVERAGE_EN
    fdata.push_back(100);
    fdata.push_back(101);
    fdata.push_back(102);
    fdata.push_back(104);
    do_scan(4'b0001, 4, "avg");
    rd_sel = 2'd0;
    #1;
    check("avg_101", rd_data, 101);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
